core_dbg_unit: RTL and testbench
================================

// Module: core_dbg_unit
// PURPOSE
//  Core-side responder for the debug command bus. Executes halt/resume, register-file read/write
//  and IF-stage PC read/write requests issued by the system debug master.
//  Drives the core pipeline stall, regfile debug port and PC-override/flush port.
//  Holds done until the master withdraws the command.
// PARAMETERS
//  HALT_ON_RESET  0             1: core comes out of reset halted (halt_o=1)
//  ERR_VAL        32'hDEAD_BEEF  dbg_data_o value for reg/PC access attempted while core not halted
// PORTS
//  clk            in   1   clock
//  rst_i          in   1   reset: synchronous, active-high
//  dbg_cmd_i      in   8   01 halt, 02 resume, 03 rd reg, 04 wr reg, 05 rd PC, 06 wr PC, 00 none
//  dbg_addr_i     in   32  register index in [4:0]; [31:5] ignored
//  dbg_data_i     in   32  write data for cmd 04/06
//  dbg_data_o     out  32  read result (registered)
//  dbg_done_o     out  1   command complete (registered level)
//  halt_o         out  1   stall request to the core pipeline
//  core_halted_i  in   1   core drained and stopped (ack of halt_o)
//  rf_raddr_o     out  5   regfile debug read index
//  rf_rdata_i     in   32  regfile read data, combinational from rf_raddr_o
//  rf_waddr_o     out  5   regfile debug write index
//  rf_wdata_o     out  32  regfile debug write data
//  rf_we_o        out  1   regfile debug write strobe (1-cycle pulse)
//  pc_i           in   32  current IF-stage PC
//  pc_o           out  32  new IF-stage PC
//  pc_we_o        out  1   load pc_o into IF (1-cycle pulse)
//  flush_o        out  1   flush pipeline (1-cycle pulse, coincident with pc_we_o)
// BEHAVIOUR
//  Reset: state IDLE; dbg_done_o=0, dbg_data_o=0, halt_o=HALT_ON_RESET, rf_we_o=pc_we_o=flush_o=0.
//   Reset mid-command aborts it: no write pulse, no done; halt_o returns to HALT_ON_RESET.
//  States: IDLE, EXEC, HALT_WAIT, DONE. Cycle 0 = first edge where IDLE sees dbg_cmd_i != 0.
//  IDLE: on cmd!=0, latch cmd, addr[4:0] and data_i.
//   Next state: HALT_WAIT for 01, EXEC for all other commands. cmd==0: stay.
//  HALT_WAIT (cmd 01): halt_o=1 from cycle 1; halted flag set.
//   Stay until core_halted_i=1, then DONE. No timeout.
//  EXEC: exactly one cycle (cycle 1), then DONE. Actions by latched cmd:
//   02: clear halted flag; halt_o=0 from cycle 1.
//   03: rf_raddr_o=addr; dbg_data_o<=rf_rdata_i.
//   04: rf_we_o=1, rf_waddr_o=addr, rf_wdata_o=data. Write to x0 is suppressed (rf_we_o stays 0).
//   05: dbg_data_o<=pc_i.
//   06: pc_we_o=1, flush_o=1, pc_o=data.
//   03..06 while halted flag=0: no strobes, dbg_data_o<=ERR_VAL.
//   Unknown cmd: no side effect, dbg_data_o unchanged.
//  DONE: dbg_done_o=1. Earliest at cycle 2, i.e. 2 cycles after the command is seen.
//   Stay while dbg_cmd_i!=0. When dbg_cmd_i==0, go to IDLE; done=0 next cycle.
//   Master drops cmd combinationally on done, so done depends only on state (no comb path cmd->done).
//  Re-issued command after IDLE re-executes; all commands are idempotent.
//  Halt when already halted: HALT_WAIT exits on the first cycle core_halted_i=1. Resume when running: no-op, done.
//  dbg_data_o holds its last value until the next 03/05 or error completion.
//  Strobes (rf_we_o, pc_we_o, flush_o) are never asserted outside EXEC.
//  halt_o is a direct function of the halted flag.
//  Idle outputs: rf_raddr_o, rf_waddr_o, rf_wdata_o and pc_o hold the latched values.
// TESTING
//  Reset with HALT_ON_RESET=0, cmd=00 -> done=0, data=0, halt_o=0, no strobes for 10 cycles.
//  cmd=01, core_halted_i rises 3 cycles after halt_o -> halt_o=1 at cycle 1.
//   done=1 the cycle after ack; cmd->0 gives done=0 next cycle.
//  Halted; cmd=04 addr=5 data=0x1234_5678 -> single rf_we_o pulse at cycle 1, waddr=5, done at cycle 2.
//   cmd=03 addr=5 with rf_rdata_i=0x1234_5678 -> data_o=0x1234_5678.
//  Halted; cmd=06 data=0x0000_0100 -> pc_we_o and flush_o pulse together, pc_o=0x100.
//   cmd=05 with pc_i=0x100 -> data_o=0x100. cmd=04 addr=0 -> no rf_we_o, done at cycle 2.
//  Running (not halted); cmd=03 -> no access, data_o=ERR_VAL, done at cycle 2.
//   cmd=02 -> halt_o stays 0, done at cycle 2.
//  rst_i asserted in HALT_WAIT and in EXEC of cmd 06 -> IDLE next cycle, no pc_we_o, done=0.

Source files
------------

// File: rtl/core_dbg_unit.sv
// Core-side debug command responder: halt/resume, regfile read/write and IF-stage PC read/write.
// Commands are latched in IDLE, executed in EXEC (one cycle) or HALT_WAIT, and acknowledged
// with a registered done level that is held until the master withdraws the command.
module core_dbg_unit #(
  parameter bit          HALT_ON_RESET = 1'b0,
  parameter logic [31:0] ERR_VAL       = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst_i,
  input  logic [7:0]  dbg_cmd_i,
  input  logic [31:0] dbg_addr_i,
  input  logic [31:0] dbg_data_i,
  output logic [31:0] dbg_data_o,
  output logic        dbg_done_o,
  output logic        halt_o,
  input  logic        core_halted_i,
  output logic [4:0]  rf_raddr_o,
  input  logic [31:0] rf_rdata_i,
  output logic [4:0]  rf_waddr_o,
  output logic [31:0] rf_wdata_o,
  output logic        rf_we_o,
  input  logic [31:0] pc_i,
  output logic [31:0] pc_o,
  output logic        pc_we_o,
  output logic        flush_o
);

  localparam logic [7:0] CmdNone   = 8'h00;
  localparam logic [7:0] CmdHalt   = 8'h01;
  localparam logic [7:0] CmdResume = 8'h02;
  localparam logic [7:0] CmdRdReg  = 8'h03;
  localparam logic [7:0] CmdWrReg  = 8'h04;
  localparam logic [7:0] CmdRdPc   = 8'h05;
  localparam logic [7:0] CmdWrPc   = 8'h06;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StHaltWait,
    StDone
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [4:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        halted_q, halted_d;
  logic        done_q, done_d;
  logic        rf_we, pc_we;
  logic        access_cmd;

  // Upper address bits carry no meaning for a register index.
  logic unused_addr;
  assign unused_addr = ^dbg_addr_i[31:5];

  // Commands that touch the regfile or PC; these need the core to be halted.
  assign access_cmd = (cmd_q >= CmdRdReg) && (cmd_q <= CmdWrPc);

  // Next-state, latch capture, execution and strobe generation.
  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    halted_d = halted_q;
    rf_we    = 1'b0;
    pc_we    = 1'b0;

    case (state_q)
      StIdle: begin
        if (dbg_cmd_i != CmdNone) begin
          cmd_d   = dbg_cmd_i;
          addr_d  = dbg_addr_i[4:0];
          wdata_d = dbg_data_i;
          if (dbg_cmd_i == CmdHalt) begin
            // Flag moves on the capture edge so halt_o changes in the first command cycle.
            halted_d = 1'b1;
            state_d  = StHaltWait;
          end else begin
            if (dbg_cmd_i == CmdResume) begin
              halted_d = 1'b0;
            end
            state_d = StExec;
          end
        end
      end

      StHaltWait: begin
        if (core_halted_i) begin
          state_d = StDone;
        end
      end

      StExec: begin
        state_d = StDone;
        if (access_cmd) begin
          if (!halted_q) begin
            rdata_d = ERR_VAL;
          end else begin
            case (cmd_q)
              CmdRdReg: rdata_d = rf_rdata_i;
              CmdWrReg: rf_we   = (addr_q != 5'd0);
              CmdRdPc:  rdata_d = pc_i;
              CmdWrPc:  pc_we   = 1'b1;
              default:  ;
            endcase
          end
        end
      end

      StDone: begin
        if (dbg_cmd_i == CmdNone) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase

    // Registered done: a function of state only, so no combinational cmd->done path.
    done_d = (state_d == StDone);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_q  <= StIdle;
      cmd_q    <= CmdNone;
      addr_q   <= 5'd0;
      wdata_q  <= 32'd0;
      rdata_q  <= 32'd0;
      halted_q <= HALT_ON_RESET;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      halted_q <= halted_d;
      done_q   <= done_d;
    end
  end

  // Output mapping; reset in the EXEC cycle suppresses the write pulses.
  always_comb begin
    rf_we_o    = rf_we & ~rst_i;
    pc_we_o    = pc_we & ~rst_i;
    flush_o    = pc_we & ~rst_i;
    halt_o     = halted_q;
    dbg_done_o = done_q;
    dbg_data_o = rdata_q;
    rf_raddr_o = addr_q;
    rf_waddr_o = addr_q;
    rf_wdata_o = wdata_q;
    pc_o       = wdata_q;
  end

endmodule

// File: tb/tb_core_dbg_unit.sv
// Self-checking bench for core_dbg_unit: transaction-level model plus per-cycle comparison.
module tb_core_dbg_unit;

  localparam logic [31:0] ErrVal = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [7:0]  dbg_cmd_i;
  logic [31:0] dbg_addr_i, dbg_data_i, dbg_data_o;
  logic        dbg_done_o, halt_o, core_halted_i;
  logic [4:0]  rf_raddr_o, rf_waddr_o;
  logic [31:0] rf_rdata_i, rf_wdata_o, pc_i, pc_o;
  logic        rf_we_o, pc_we_o, flush_o;

  core_dbg_unit #(
    .HALT_ON_RESET(1'b0),
    .ERR_VAL      (ErrVal)
  ) dut (
    .clk          (clk),
    .rst_i        (rst_i),
    .dbg_cmd_i    (dbg_cmd_i),
    .dbg_addr_i   (dbg_addr_i),
    .dbg_data_i   (dbg_data_i),
    .dbg_data_o   (dbg_data_o),
    .dbg_done_o   (dbg_done_o),
    .halt_o       (halt_o),
    .core_halted_i(core_halted_i),
    .rf_raddr_o   (rf_raddr_o),
    .rf_rdata_i   (rf_rdata_i),
    .rf_waddr_o   (rf_waddr_o),
    .rf_wdata_o   (rf_wdata_o),
    .rf_we_o      (rf_we_o),
    .pc_i         (pc_i),
    .pc_o         (pc_o),
    .pc_we_o      (pc_we_o),
    .flush_o      (flush_o)
  );

  always #5 clk = ~clk;

  // Environment: a regfile and an IF PC register driven only by the DUT strobes.
  logic [31:0] env_regs [32];
  logic [31:0] env_pc;
  assign rf_rdata_i = env_regs[rf_raddr_o];
  assign pc_i       = env_pc;
  always @(posedge clk) begin
    if (rf_we_o) env_regs[rf_waddr_o] <= rf_wdata_o;
    if (pc_we_o) env_pc <= pc_o;
  end

  // Reference model state.
  logic [31:0] m_regs [32];
  logic [31:0] m_pc;
  logic        m_halted;
  logic [4:0]  m_addr;
  logic [31:0] m_wdata;
  logic        m_lat_valid;
  logic        exp_done, exp_halt, exp_rf_we, exp_pc_we;
  logic [31:0] exp_data;
  logic        chk_en;

  int nvec = 0;
  int nerr = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Per-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("done", 32'(dbg_done_o), 32'(exp_done));
      chk("data", dbg_data_o, exp_data);
      chk("halt", 32'(halt_o), 32'(exp_halt));
      chk("rf_we", 32'(rf_we_o), 32'(exp_rf_we));
      chk("pc_we", 32'(pc_we_o), 32'(exp_pc_we));
      chk("flush", 32'(flush_o), 32'(exp_pc_we));
      if (m_lat_valid) begin
        chk("rf_raddr", 32'(rf_raddr_o), 32'(m_addr));
        chk("rf_waddr", 32'(rf_waddr_o), 32'(m_addr));
        chk("rf_wdata", rf_wdata_o, m_wdata);
        chk("pc_o", pc_o, m_wdata);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    dbg_cmd_i = 8'h00;
    core_halted_i = 1'b0;
    exp_rf_we = 1'b0;
    exp_pc_we = 1'b0;
    tick();
    rst_i = 1'b0;
    exp_done = 1'b0;
    exp_data = 32'd0;
    m_halted = 1'b0;
    exp_halt = 1'b0;
    m_lat_valid = 1'b0;
    chk_en = 1'b1;
  endtask

  // One full handshake: present the command, wait for done, hold, withdraw.
  task automatic do_cmd(input logic [7:0] c, input logic [31:0] a, input logic [31:0] d,
                        input int ack_dly, input int hold);
    logic [31:0] newdata;
    logic        acc;
    dbg_cmd_i = c;
    dbg_addr_i = a;
    dbg_data_i = d;
    if (c == 8'h00) begin
      tick();
      return;
    end
    tick();
    m_addr = a[4:0];
    m_wdata = d;
    m_lat_valid = 1'b1;
    if (c == 8'h01) begin
      m_halted = 1'b1;
      exp_halt = 1'b1;
      for (int k = 0; k < ack_dly; k++) tick();
      core_halted_i = 1'b1;
      tick();
      core_halted_i = 1'b0;
    end else if (c == 8'h02) begin
      m_halted = 1'b0;
      exp_halt = 1'b0;
      tick();
    end else begin
      newdata = exp_data;
      acc = (c >= 8'h03) && (c <= 8'h06);
      if (acc && !m_halted) begin
        newdata = ErrVal;
      end else if (acc) begin
        case (c)
          8'h03: newdata = m_regs[a[4:0]];
          8'h04: if (a[4:0] != 5'd0) begin
            exp_rf_we = 1'b1;
            m_regs[a[4:0]] = d;
          end
          8'h05: newdata = m_pc;
          default: begin
            exp_pc_we = 1'b1;
            m_pc = d;
          end
        endcase
      end
      tick();
      exp_rf_we = 1'b0;
      exp_pc_we = 1'b0;
      exp_data = newdata;
    end
    exp_done = 1'b1;
    for (int k = 0; k < hold; k++) tick();
    dbg_cmd_i = 8'h00;
    tick();
    exp_done = 1'b0;
  endtask

  initial begin
    logic [7:0]  rc;
    logic [31:0] ra;
    int          r;
    chk_en = 1'b0;
    rst_i = 1'b1;
    dbg_cmd_i = 8'h00;
    dbg_addr_i = 32'd0;
    dbg_data_i = 32'd0;
    core_halted_i = 1'b0;
    exp_rf_we = 1'b0;
    exp_pc_we = 1'b0;
    for (int i = 0; i < 32; i++) begin
      env_regs[i] = $urandom;
      m_regs[i] = env_regs[i];
    end
    env_pc = $urandom;
    m_pc = env_pc;
    tick();
    do_reset();
    for (int i = 0; i < 10; i++) tick();

    // Running: access is refused, resume is a no-op.
    do_cmd(8'h03, 32'd5, 32'd0, 0, 0);
    chk("err_lit", dbg_data_o, 32'hDEAD_BEEF);
    do_cmd(8'h02, 32'd0, 32'd0, 0, 1);
    chk("resume_running_lit", 32'(halt_o), 32'd0);

    // Halt with a 3-cycle ack, then regfile and PC access.
    do_cmd(8'h01, 32'd0, 32'd0, 3, 0);
    chk("halt_lit", 32'(halt_o), 32'd1);
    do_cmd(8'h04, 32'd5, 32'h1234_5678, 0, 2);
    chk("rf_write_lit", env_regs[5], 32'h1234_5678);
    do_cmd(8'h03, 32'hFFFF_FFE5, 32'd0, 0, 0);
    chk("rf_read_lit", dbg_data_o, 32'h1234_5678);
    do_cmd(8'h06, 32'd0, 32'h0000_0100, 0, 0);
    do_cmd(8'h05, 32'd0, 32'd0, 0, 1);
    chk("pc_read_lit", dbg_data_o, 32'h0000_0100);
    do_cmd(8'h04, 32'd0, 32'hFFFF_FFFF, 0, 0);
    chk("x0_write_lit", env_regs[0], m_regs[0]);
    do_cmd(8'h07, 32'd3, 32'd0, 0, 0);
    chk("unknown_lit", dbg_data_o, 32'h0000_0100);
    do_cmd(8'h01, 32'd0, 32'd0, 0, 0);

    // Reset during HALT_WAIT.
    dbg_cmd_i = 8'h01;
    tick();
    m_halted = 1'b1;
    exp_halt = 1'b1;
    m_lat_valid = 1'b1;
    m_addr = 5'd0;
    m_wdata = 32'd0;
    tick();
    tick();
    do_reset();
    tick();
    chk("rst_hw_halt_lit", 32'(halt_o), 32'd0);

    // Reset during EXEC of a PC write: no load, no done.
    do_cmd(8'h01, 32'd0, 32'd0, 1, 0);
    dbg_cmd_i = 8'h06;
    dbg_data_i = 32'hCAFE_0000;
    dbg_addr_i = 32'd0;
    tick();
    m_addr = 5'd0;
    m_wdata = 32'hCAFE_0000;
    do_reset();
    tick();
    chk("rst_exec_pc_lit", env_pc, 32'h0000_0100);

    // Randomized command stream.
    for (int n = 0; n < 250; n++) begin
      r = $urandom_range(0, 9);
      case (r)
        0: rc = 8'h00;
        1: rc = 8'h01;
        2: rc = 8'h02;
        3, 4: rc = 8'h03;
        5, 6: rc = 8'h04;
        7: rc = 8'h05;
        8: rc = 8'h06;
        default: rc = 8'($urandom_range(7, 255));
      endcase
      ra = $urandom;
      if ($urandom_range(0, 3) == 0) ra[4:0] = 5'd0;
      do_cmd(rc, ra, $urandom, $urandom_range(0, 3), $urandom_range(0, 2));
    end
    for (int i = 0; i < 32; i++) chk("final_regs", env_regs[i], m_regs[i]);
    chk("final_pc", env_pc, m_pc);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
